mux_key_table: RTL and testbench

//  Runtime-programmable key->data lookup table. Successor to the fixed-LUT key mux.
//  The table is written through a write port instead of a static lut bus.

---
 rtl/mux_key_table.sv | 178 +++++++++++++++++
 tb/tb_mux_key_table.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key_table.sv
// mux_key_table: runtime-programmable key->data lookup table.
// Entries are loaded or invalidated through a write port. Lookups use a
// valid/ready request and return a registered, back-pressurable response
// carrying data, hit flag and the lowest matching index.
// Optional feature macro: MUX_KEY_TABLE_STATS_EN adds saturating hit/miss
// counters (hit_cnt, miss_cnt) with a synchronous clear (stats_clr).
module mux_key_table #(
    parameter  int NR_KEY   = 4,
    parameter  int KEY_LEN  = 3,
    parameter  int DATA_LEN = 8,
    localparam int IDX_LEN  = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                wr_vld,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    input  logic [DATA_LEN-1:0] default_out,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_hit,
    output logic [IDX_LEN-1:0]  resp_idx
`ifdef MUX_KEY_TABLE_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Table contents
    logic [NR_KEY-1:0]   vld_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    // Lookup result against the current (pre-write) table
    logic [NR_KEY-1:0]   match_s;
    logic                hit_s;
    logic [IDX_LEN-1:0]  idx_s;
    logic [DATA_LEN-1:0] data_s;
    logic                accept_s;

    // Response register
    logic [0:0]          state_q, state_d;
    logic [DATA_LEN-1:0] resp_data_q;
    logic                resp_hit_q;
    logic [IDX_LEN-1:0]  resp_idx_q;

    // Table storage: an addressed write loads or invalidates one entry; an
    // out-of-range index matches no entry and so changes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_en && (wr_idx == IDX_LEN'(i))) begin
                    vld_q[i]  <= wr_vld;
                    key_q[i]  <= wr_key;
                    data_q[i] <= wr_data;
                end
            end
        end
    end

    // Priority match: scan high to low so the lowest matching index wins;
    // data is selected from exactly one entry, never ORed.
    always_comb begin
        match_s = '0;
        hit_s   = 1'b0;
        idx_s   = '0;
        data_s  = default_out;
        for (int i = 0; i < NR_KEY; i++) begin
            match_s[i] = vld_q[i] & (key_q[i] == req_key);
        end
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            hit_s  = match_s[i] ? 1'b1        : hit_s;
            idx_s  = match_s[i] ? IDX_LEN'(i) : idx_s;
            data_s = match_s[i] ? data_q[i]   : data_s;
        end
    end

    // Handshake: a slot is free when empty or being drained this cycle.
    always_comb begin
        req_ready = (state_q == ST_EMPTY) | resp_ready;
        accept_s  = req_valid & req_ready;
    end

    // Response FSM next state: fill on accept, drain on ready without accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) state_d = ST_FULL;
                else          state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (resp_ready && !accept_s) state_d = ST_EMPTY;
                else                         state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Response register: payload only changes on accept, so it is held
    // stable under back-pressure and is immune to later table writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            resp_data_q <= '0;
            resp_hit_q  <= 1'b0;
            resp_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                resp_data_q <= data_s;
                resp_hit_q  <= hit_s;
                resp_idx_q  <= idx_s;
            end
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = resp_data_q;
    assign resp_hit   = resp_hit_q;
    assign resp_idx   = resp_idx_q;

`ifdef MUX_KEY_TABLE_STATS_EN
    logic [15:0] hit_cnt_q,  hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Counter next state: clear beats increment; increments saturate.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (stats_clr) begin
            hit_cnt_d  = 16'h0000;
            miss_cnt_d = 16'h0000;
        end else if (accept_s) begin
            if (hit_s) begin
                hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
            end else begin
                miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mux_key_table.sv
// Directed testbench for mux_key_table. A second instance with NR_KEY=3
// shares all inputs so that a write to index NR_KEY can be shown to be
// ignored. Counter scenarios run when MUX_KEY_TABLE_STATS_EN is defined.
module tb_mux_key_table;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 3;
    localparam int DATA_LEN = 8;
    localparam int IDX_LEN  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_en, wr_vld;
    logic [IDX_LEN-1:0]  wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                req_valid, req_ready, resp_valid, resp_ready, resp_hit;
    logic [KEY_LEN-1:0]  req_key;
    logic [DATA_LEN-1:0] default_out, resp_data;
    logic [IDX_LEN-1:0]  resp_idx;

    logic                req_ready3, resp_valid3, resp_hit3;
    logic [DATA_LEN-1:0] resp_data3;
    logic [IDX_LEN-1:0]  resp_idx3;

    logic                stats_clr;
    logic [15:0]         hit_cnt, miss_cnt, hit_cnt3, miss_cnt3;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mux_key_table #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_vld(wr_vld), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .default_out(default_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_hit(resp_hit), .resp_idx(resp_idx)
`ifdef MUX_KEY_TABLE_STATS_EN
        , .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    mux_key_table #(.NR_KEY(3), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_vld(wr_vld), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready3), .req_key(req_key),
        .default_out(default_out),
        .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_data(resp_data3),
        .resp_hit(resp_hit3), .resp_idx(resp_idx3)
`ifdef MUX_KEY_TABLE_STATS_EN
        , .stats_clr(stats_clr), .hit_cnt(hit_cnt3), .miss_cnt(miss_cnt3)
`endif
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle table write.
    task automatic wr(input logic [IDX_LEN-1:0] idx, input logic vld,
                      input logic [KEY_LEN-1:0] key, input logic [DATA_LEN-1:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_vld = vld; wr_key = key; wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    // One-cycle lookup request (accepted when ready at the edge).
    task automatic lookup(input logic [KEY_LEN-1:0] key, input logic [DATA_LEN-1:0] dflt);
        req_valid = 1'b1; req_key = key; default_out = dflt;
        step();
        req_valid = 1'b0;
    endtask

    // Reset state of the response and handshake.
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b0, 1'b0, 2'd0, 8'h00}) begin
            err_cnt++;
            $display("FAIL reset_resp: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, 12'h000);
        end
        vec_cnt++;
        if (req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Empty table: every lookup misses and returns default_out.
    task automatic test_default_miss();
        lookup(3'd3, 8'hAA);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b0, 2'd0, 8'hAA}) begin
            err_cnt++;
            $display("FAIL default_miss: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b0, 2'd0, 8'hAA});
        end
    endtask

    // Duplicate keys: the lowest index wins.
    task automatic test_priority();
        wr(2'd1, 1'b1, 3'd5, 8'h11);
        wr(2'd2, 1'b1, 3'd5, 8'h22);
        lookup(3'd5, 8'h00);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b1, 2'd1, 8'h11}) begin
            err_cnt++;
            $display("FAIL priority: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b1, 2'd1, 8'h11});
        end
    endtask

    // Lookup in the same cycle as a write sees the old table.
    task automatic test_same_cycle();
        wr_en = 1'b1; wr_idx = 2'd0; wr_vld = 1'b1; wr_key = 3'd2; wr_data = 8'h33;
        req_valid = 1'b1; req_key = 3'd2; default_out = 8'h5A;
        step();
        wr_en = 1'b0; req_valid = 1'b0;
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b0, 2'd0, 8'h5A}) begin
            err_cnt++;
            $display("FAIL same_cycle_old: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b0, 2'd0, 8'h5A});
        end
        lookup(3'd2, 8'h5A);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b1, 2'd0, 8'h33}) begin
            err_cnt++;
            $display("FAIL same_cycle_new: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b1, 2'd0, 8'h33});
        end
    endtask

    // Back-pressure holds the response and stalls requests; then 1/clk streaming.
    task automatic test_back_to_back();
        logic [KEY_LEN-1:0]  keys [3];
        logic [DATA_LEN-1:0] exp  [3];
        logic [IDX_LEN-1:0]  eidx [3];
        logic                ehit [3];
        keys[0] = 3'd5; exp[0] = 8'h11; eidx[0] = 2'd1; ehit[0] = 1'b1;
        keys[1] = 3'd3; exp[1] = 8'h77; eidx[1] = 2'd0; ehit[1] = 1'b0;
        keys[2] = 3'd2; exp[2] = 8'h33; eidx[2] = 2'd0; ehit[2] = 1'b1;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_key = 3'd5; default_out = 8'h77;
        #1;
        for (int c = 0; c < 3; c++) begin
            vec_cnt++;
            if ({req_ready, resp_valid, resp_hit, resp_idx, resp_data} !== {1'b0, 1'b1, 1'b1, 2'd0, 8'h33}) begin
                err_cnt++;
                $display("FAIL stall_hold c=%0d: got %h want %h", c, {req_ready, resp_valid, resp_hit, resp_idx, resp_data}, {1'b0, 1'b1, 1'b1, 2'd0, 8'h33});
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL ready_release: got %b want 1", req_ready);
        end
        for (int s = 0; s < 3; s++) begin
            req_key = keys[s];
            step();
            vec_cnt++;
            if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, ehit[s], eidx[s], exp[s]}) begin
                err_cnt++;
                $display("FAIL stream s=%0d: got %h want %h", s, {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, ehit[s], eidx[s], exp[s]});
            end
        end
        req_valid = 1'b0;
        step();
        vec_cnt++;
        if (resp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL drain: got %b want 0", resp_valid);
        end
    endtask

    // Invalidate, out-of-range write, held response vs later writes.
    task automatic test_invalidate();
        wr(2'd1, 1'b0, 3'd5, 8'h00);
        lookup(3'd5, 8'h00);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b1, 2'd2, 8'h22}) begin
            err_cnt++;
            $display("FAIL invalidate: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b1, 2'd2, 8'h22});
        end
        // index 3 is in range for the 4-entry table, out of range for the 3-entry one
        wr(2'd3, 1'b1, 3'd7, 8'h77);
        lookup(3'd7, 8'hC3);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b1, 2'd3, 8'h77}) begin
            err_cnt++;
            $display("FAIL idx3_write: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b1, 2'd3, 8'h77});
        end
        vec_cnt++;
        if ({resp_valid3, resp_hit3, resp_idx3, resp_data3} !== {1'b1, 1'b0, 2'd0, 8'hC3}) begin
            err_cnt++;
            $display("FAIL oob_write_ignored: got %h want %h", {resp_valid3, resp_hit3, resp_idx3, resp_data3}, {1'b1, 1'b0, 2'd0, 8'hC3});
        end
        resp_ready = 1'b0;
        wr(2'd3, 1'b1, 3'd7, 8'h99);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b1, 2'd3, 8'h77}) begin
            err_cnt++;
            $display("FAIL held_vs_write: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b1, 2'd3, 8'h77});
        end
        resp_ready = 1'b1;
        step();
    endtask

`ifdef MUX_KEY_TABLE_STATS_EN
    // Counters: classify, saturate, clear with priority over increment.
    task automatic test_stats();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        vec_cnt++;
        if ({hit_cnt, miss_cnt} !== 32'h0) begin
            err_cnt++;
            $display("FAIL stats_clr0: got %h want 0", {hit_cnt, miss_cnt});
        end
        lookup(3'd5, 8'h00);
        lookup(3'd7, 8'h00);
        lookup(3'd1, 8'h00);
        vec_cnt++;
        if ({hit_cnt, miss_cnt} !== {16'd2, 16'd1}) begin
            err_cnt++;
            $display("FAIL stats_count: got %h want %h", {hit_cnt, miss_cnt}, {16'd2, 16'd1});
        end
        req_valid = 1'b1; req_key = 3'd5;
        repeat (65533) @(posedge clk);
        #1;
        vec_cnt++;
        if ({hit_cnt, miss_cnt} !== {16'hFFFF, 16'd1}) begin
            err_cnt++;
            $display("FAIL stats_reach_max: got %h want %h", {hit_cnt, miss_cnt}, {16'hFFFF, 16'd1});
        end
        step();
        vec_cnt++;
        if (hit_cnt !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL stats_saturate: got %h want ffff", hit_cnt);
        end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0; req_valid = 1'b0;
        vec_cnt++;
        if ({hit_cnt, miss_cnt} !== 32'h0) begin
            err_cnt++;
            $display("FAIL stats_clr_priority: got %h want 0", {hit_cnt, miss_cnt});
        end
        step();
    endtask
`endif

    // Asynchronous reset while a response is held.
    task automatic test_reset_midop();
        resp_ready = 1'b0;
        lookup(3'd5, 8'h00);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (resp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: got %b want 0", resp_valid);
        end
        step();
        rst_n = 1'b1; resp_ready = 1'b1;
        step();
        lookup(3'd5, 8'h4E);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b0, 2'd0, 8'h4E}) begin
            err_cnt++;
            $display("FAIL post_reset_miss5: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b0, 2'd0, 8'h4E});
        end
        lookup(3'd2, 8'hB1);
        vec_cnt++;
        if ({resp_valid, resp_hit, resp_idx, resp_data} !== {1'b1, 1'b0, 2'd0, 8'hB1}) begin
            err_cnt++;
            $display("FAIL post_reset_miss2: got %h want %h", {resp_valid, resp_hit, resp_idx, resp_data}, {1'b1, 1'b0, 2'd0, 8'hB1});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_vld = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
        req_valid = 1'b0; req_key = '0; default_out = '0;
        resp_ready = 1'b1; stats_clr = 1'b0;
        #1;
        test_reset();
        test_default_miss();
        test_priority();
        test_same_cycle();
        test_back_to_back();
        test_invalidate();
`ifdef MUX_KEY_TABLE_STATS_EN
        test_stats();
`endif
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
